// File: rtl/linearb_hls_deadlock_reporter.sv
// linearb_hls_deadlock_reporter
//   Consumer end of the lineArb HLS deadlock monitor. Qualifies the block
//   flag over THRESHOLD consecutive cycles, freezes a snapshot of the
//   per-lane block_info bytes, then emits one report word per blocked lane
//   over a valid/ready stream. Illegal monitor encodings raise a sticky flag.
//
// Ports
//   clk_i               clock, all flops rising edge
//   rst_i               asynchronous active-high reset
//   block_i             monitor block flag
//   axis_block_info_i   byte n = ~(8'h1<<n) when lane n blocked, else 8'h00
//   clear_i             single-cycle rearm request
//   deadlock_o          sticky deadlock-qualified flag
//   malformed_o         sticky illegal-encoding flag
//   block_cycles_o      consecutive block cycles of current/last run (saturating)
//   rpt_valid_o/rpt_ready_i  report stream handshake
//   rpt_chan_o/rpt_code_o/rpt_last_o  report lane, snapshot byte, final word
module linearb_hls_deadlock_reporter #(
  parameter int NUM_CHAN  = 8,
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 32,
  parameter int CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  block_i,
  input  logic [8*NUM_CHAN-1:0] axis_block_info_i,
  input  logic                  clear_i,
  output logic                  deadlock_o,
  output logic                  malformed_o,
  output logic [CNT_W-1:0]      block_cycles_o,
  output logic                  rpt_valid_o,
  input  logic                  rpt_ready_i,
  output logic [CHAN_W-1:0]     rpt_chan_o,
  output logic [7:0]            rpt_code_o,
  output logic                  rpt_last_o
);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_LATCHED, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic                    deadlock_q, deadlock_d;
  logic                    malformed_q, malformed_d;
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CHAN-1:0]     mask_q, mask_d;
  logic [8*NUM_CHAN-1:0]   snap_q, snap_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic [NUM_CHAN-1:0]     info_nz;
  logic                    bad_code;
  logic [CHAN_W-1:0]       sel_chan;
  logic [7:0]              sel_code;
  logic [NUM_CHAN-1:0]     sel_onehot;
  logic                    single_left;
  logic                    accept;
  logic                    latch;

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  // Zero or one bit set; an empty mask still yields one final word.
  assign single_left = ((mask_q & (mask_q - NUM_CHAN'(1))) == '0);
  assign accept      = valid_q & rpt_ready_i;

  // Per-lane decode: nonzero bytes, legality, and lowest-set-lane select.
  always_comb begin
    logic [7:0] lane_byte;
    logic [7:0] legal;
    info_nz    = '0;
    bad_code   = 1'b0;
    sel_chan   = '0;
    sel_code   = '0;
    sel_onehot = '0;
    for (int n = 0; n < NUM_CHAN; n++) begin
      lane_byte  = axis_block_info_i[n*8 +: 8];
      legal      = ~(8'd1 << n);
      info_nz[n] = (lane_byte != 8'h00);
      if (info_nz[n] && ((lane_byte != legal) || !block_i)) bad_code = 1'b1;
    end
    // Descending scan so the lowest set lane is the last one written.
    for (int n = NUM_CHAN - 1; n >= 0; n--) begin
      if (mask_q[n]) begin
        sel_chan      = CHAN_W'(n);
        sel_code      = snap_q[n*8 +: 8];
        sel_onehot    = '0;
        sel_onehot[n] = 1'b1;
      end
    end
  end

  // NOTE: every next-state variable gets its hold value first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    deadlock_d  = deadlock_q;
    malformed_d = malformed_q | bad_code;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    snap_d      = snap_q;
    latch       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (block_i) begin
          cnt_d = CNT_W'(1);
          if (THRESHOLD == 1) latch   = 1'b1;
          else                state_d = S_QUAL;
        end else begin
          cnt_d = '0;
        end
      end
      S_QUAL: begin
        if (block_i) begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_W'(THRESHOLD - 1)) latch = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_LATCHED: begin
        if (block_i) cnt_d = cnt_inc;
        if (accept) begin
          mask_d = mask_q & ~sel_onehot;
          if (single_left) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (block_i) cnt_d = cnt_inc;
      end
      default: state_d = S_IDLE;
    endcase

    if (latch) begin
      snap_d     = axis_block_info_i;
      mask_d     = info_nz;
      deadlock_d = 1'b1;
      valid_d    = 1'b1;
      state_d    = S_LATCHED;
      if (info_nz == '0) malformed_d = 1'b1;
    end

    // Rearm overrides everything, including a coincident latch.
    if (clear_i) begin
      state_d     = S_IDLE;
      deadlock_d  = 1'b0;
      malformed_d = 1'b0;
      valid_d     = 1'b0;
      cnt_d       = '0;
      mask_d      = '0;
      snap_d      = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only so every flop
  // samples the pre-edge values. The snapshot is a plain register bank, so it
  // is reset along with the rest to keep outputs defined.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      deadlock_q  <= 1'b0;
      malformed_q <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      mask_q      <= '0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      deadlock_q  <= deadlock_d;
      malformed_q <= malformed_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      snap_q      <= snap_d;
    end
  end

  assign deadlock_o     = deadlock_q;
  assign malformed_o    = malformed_q;
  assign block_cycles_o = cnt_q;
  assign rpt_valid_o    = valid_q;
  // Report fields read as zero whenever no word is offered.
  assign rpt_chan_o     = valid_q ? sel_chan : '0;
  assign rpt_code_o     = valid_q ? sel_code : 8'h00;
  assign rpt_last_o     = valid_q & single_left;

endmodule
